// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared error-bit indices, W checker states and monitored AXI port structs
package axi_pkg;

  localparam int unsigned ErrWidth   = 5;
  localparam int unsigned ErrWLen    = 0;
  localparam int unsigned ErrWOrphan = 1;
  localparam int unsigned ErrBOrphan = 2;
  localparam int unsigned ErrROrphan = 3;
  localparam int unsigned ErrAwOvf   = 4;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

  // Only the fields the monitor observes
  typedef struct packed {
    logic       aw_valid;
    logic [7:0] aw_len;
    logic       w_valid;
    logic       w_last;
    logic       b_ready;
    logic       ar_valid;
    logic       r_ready;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic b_valid;
    logic ar_ready;
    logic r_valid;
    logic r_last;
  } axi_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small FIFO with optional first-word fall-through
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0]      r_rd_ptr;
  logic [AddrW-1:0]      r_wr_ptr;
  logic [CntW-1:0]       r_cnt;
  logic                  w_is_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  // Status and read path; an entry pushed into an empty FIFO is visible and poppable at once
  always_comb begin
    w_is_empty = (r_cnt == '0);
    w_full     = (r_cnt == CntW'(DEPTH));
    w_bypass   = FALL_THROUGH & w_is_empty & push_i & pop_i;
    w_push     = push_i & ~w_full & ~w_bypass;
    w_pop      = pop_i & ~w_is_empty;
    full_o     = w_full;
    empty_o    = w_is_empty & ~(FALL_THROUGH & push_i);
    data_o     = (FALL_THROUGH && w_is_empty) ? data_i : r_mem[r_rd_ptr];
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_burst_monitor.sv
// rtl/axi_burst_monitor.sv - passive AXI4 tap: handshake statistics and burst-integrity flags
module axi_burst_monitor
  import axi_pkg::*;
#(
  parameter int unsigned MaxWrTxns = 8,
  parameter int unsigned CntWidth  = 32,
  parameter type         req_t     = axi_req_t,
  parameter type         resp_t    = axi_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  req_t                axi_req_i,
  input  resp_t               axi_rsp_i,
  output logic [CntWidth-1:0] aw_cnt_o,
  output logic [CntWidth-1:0] w_cnt_o,
  output logic [CntWidth-1:0] b_cnt_o,
  output logic [CntWidth-1:0] ar_cnt_o,
  output logic [CntWidth-1:0] r_cnt_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [ErrWidth-1:0] err_o,
  output logic                busy_o
);

  logic [CntWidth-1:0] r_aw_cnt, r_w_cnt, r_b_cnt, r_ar_cnt, r_r_cnt;
  logic [CntWidth-1:0] r_wr_out, r_rd_out;
  logic [ErrWidth-1:0] r_err;
  w_state_e            r_w_state;
  logic [7:0]          r_beat_idx;
  logic                r_busy;

  logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_last_hs;
  logic                w_fifo_full, w_fifo_empty, w_fifo_pop;
  logic [7:0]          w_head_len;
  logic [ErrWidth-1:0] w_err_set;
  logic [CntWidth-1:0] w_wr_out_nxt, w_rd_out_nxt;
  logic                w_out_busy_nxt;
  logic                w_w_last;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CntWidth'(1) : v;
  endfunction

  // Pending AW lengths; fall-through lets a same-cycle AW serve the W beat that arrives with it
  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   (8),
    .DEPTH        (MaxWrTxns)
  ) u_len_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  (axi_req_i.aw_len),
    .push_i  (w_aw_hs),
    .data_o  (w_head_len),
    .pop_i   (w_fifo_pop)
  );

  // Handshake decode, error events and next outstanding counts
  always_comb begin
    w_aw_hs     = axi_req_i.aw_valid & axi_rsp_i.aw_ready;
    w_w_hs      = axi_req_i.w_valid  & axi_rsp_i.w_ready;
    w_b_hs      = axi_rsp_i.b_valid  & axi_req_i.b_ready;
    w_ar_hs     = axi_req_i.ar_valid & axi_rsp_i.ar_ready;
    w_r_hs      = axi_rsp_i.r_valid  & axi_req_i.r_ready;
    w_r_last_hs = w_r_hs & axi_rsp_i.r_last;
    w_w_last    = axi_req_i.w_last;
    w_fifo_pop  = w_w_hs & w_w_last & ~w_fifo_empty;

    // Beat index is 0 whenever idle, so one compare covers both states
    w_err_set             = '0;
    w_err_set[ErrAwOvf]   = w_aw_hs & w_fifo_full;
    w_err_set[ErrWOrphan] = w_w_hs & w_fifo_empty;
    w_err_set[ErrWLen]    = w_w_hs & ~w_fifo_empty &
                            (w_w_last ? (r_beat_idx != w_head_len) : (r_beat_idx == w_head_len));
    w_err_set[ErrBOrphan] = w_b_hs & ~w_aw_hs & (r_wr_out == '0);
    w_err_set[ErrROrphan] = w_r_hs & ~w_ar_hs & (r_rd_out == '0);

    w_wr_out_nxt = r_wr_out;
    case ({w_aw_hs, w_b_hs})
      2'b10:   w_wr_out_nxt = r_wr_out + CntWidth'(1);
      2'b01:   if (r_wr_out != '0) w_wr_out_nxt = r_wr_out - CntWidth'(1);
      default: w_wr_out_nxt = r_wr_out;
    endcase

    w_rd_out_nxt = r_rd_out;
    case ({w_ar_hs, w_r_last_hs})
      2'b10:   w_rd_out_nxt = r_rd_out + CntWidth'(1);
      2'b01:   if (r_rd_out != '0) w_rd_out_nxt = r_rd_out - CntWidth'(1);
      default: w_rd_out_nxt = r_rd_out;
    endcase

    w_out_busy_nxt = (w_wr_out_nxt != '0) | (w_rd_out_nxt != '0);
  end

  // Statistics, outstanding counters and sticky errors; clear wipes stats and errors only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_cnt <= '0;
      r_w_cnt  <= '0;
      r_b_cnt  <= '0;
      r_ar_cnt <= '0;
      r_r_cnt  <= '0;
      r_wr_out <= '0;
      r_rd_out <= '0;
      r_err    <= '0;
    end else begin
      r_wr_out <= w_wr_out_nxt;
      r_rd_out <= w_rd_out_nxt;
      if (clear_i) begin
        r_aw_cnt <= '0;
        r_w_cnt  <= '0;
        r_b_cnt  <= '0;
        r_ar_cnt <= '0;
        r_r_cnt  <= '0;
        r_err    <= '0;
      end else begin
        r_aw_cnt <= sat_inc(r_aw_cnt, w_aw_hs);
        r_w_cnt  <= sat_inc(r_w_cnt,  w_w_hs);
        r_b_cnt  <= sat_inc(r_b_cnt,  w_b_hs);
        r_ar_cnt <= sat_inc(r_ar_cnt, w_ar_hs);
        r_r_cnt  <= sat_inc(r_r_cnt,  w_r_hs);
        r_err    <= r_err | w_err_set;
      end
    end
  end

  // W burst tracker with registered busy flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w_state  <= W_IDLE;
      r_beat_idx <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_w_hs & ~w_fifo_empty & ~w_w_last) begin
            r_w_state  <= W_BURST;
            r_beat_idx <= 8'd1;
            r_busy     <= 1'b1;
          end else begin
            r_busy     <= w_out_busy_nxt;
          end
        end
        W_BURST: begin
          if (w_w_hs & w_w_last) begin
            r_w_state  <= W_IDLE;
            r_beat_idx <= '0;
            r_busy     <= w_out_busy_nxt;
          end else begin
            if (w_w_hs && (r_beat_idx != 8'hff)) r_beat_idx <= r_beat_idx + 8'd1;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_w_state  <= W_IDLE;
          r_beat_idx <= '0;
          r_busy     <= w_out_busy_nxt;
        end
      endcase
    end
  end

  assign aw_cnt_o         = r_aw_cnt;
  assign w_cnt_o          = r_w_cnt;
  assign b_cnt_o          = r_b_cnt;
  assign ar_cnt_o         = r_ar_cnt;
  assign r_cnt_o          = r_r_cnt;
  assign wr_outstanding_o = r_wr_out;
  assign rd_outstanding_o = r_rd_out;
  assign err_o            = r_err;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_axi_burst_monitor.sv
// tb/tb_axi_burst_monitor.sv - directed bench with per-cycle reference model for axi_burst_monitor
module tb_axi_burst_monitor;
  import axi_pkg::*;

  localparam int MAXW = 8;
  localparam int CW   = 4;
  localparam int SAT  = 15;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic clear_i = 1'b0;
  axi_req_t req = '0;
  axi_rsp_t rsp = '0;
  logic [CW-1:0] aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wr_out, rd_out;
  logic [ErrWidth-1:0] err;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_burst_monitor #(
    .MaxWrTxns (MAXW),
    .CntWidth  (CW),
    .req_t     (axi_req_t),
    .resp_t    (axi_rsp_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .axi_req_i        (req),
    .axi_rsp_i        (rsp),
    .aw_cnt_o         (aw_cnt),
    .w_cnt_o          (w_cnt),
    .b_cnt_o          (b_cnt),
    .ar_cnt_o         (ar_cnt),
    .r_cnt_o          (r_cnt),
    .wr_outstanding_o (wr_out),
    .rd_outstanding_o (rd_out),
    .err_o            (err),
    .busy_o           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending burst lengths, beat counting, plain integer counters
  int m_q[$];
  int m_beats = 0;
  int m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0, m_wr = 0, m_rd = 0;
  logic [4:0] m_err = '0;
  bit m_busy = 0;
  bit m_en = 0;

  function automatic int sat(input int v, input bit en);
    return (en && v < SAT) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [4:0] e;
    int wr_old, rd_old;
    aw_hs = req.aw_valid && rsp.aw_ready;
    w_hs  = req.w_valid && rsp.w_ready;
    b_hs  = rsp.b_valid && req.b_ready;
    ar_hs = req.ar_valid && rsp.ar_ready;
    r_hs  = rsp.r_valid && req.r_ready;
    if (rst_i) begin
      m_q.delete();
      m_beats = 0;
      m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0; m_wr = 0; m_rd = 0;
      m_err = '0;
    end else begin
      e = '0;
      if (aw_hs) begin
        if (m_q.size() >= MAXW) e[4] = 1'b1;
        else m_q.push_back(int'(req.aw_len));
      end
      if (w_hs) begin
        if (m_q.size() == 0) e[1] = 1'b1;
        else if (req.w_last) begin
          if (m_beats != m_q[0]) e[0] = 1'b1;
          void'(m_q.pop_front());
          m_beats = 0;
        end else begin
          if (m_beats == m_q[0]) e[0] = 1'b1;
          if (m_beats < 255) m_beats++;
        end
      end
      wr_old = m_wr;
      rd_old = m_rd;
      if (b_hs && !aw_hs && wr_old == 0) e[2] = 1'b1;
      if (r_hs && !ar_hs && rd_old == 0) e[3] = 1'b1;
      m_wr = wr_old + int'(aw_hs) - int'(b_hs && (wr_old > 0 || aw_hs));
      m_rd = rd_old + int'(ar_hs) - int'(r_hs && rsp.r_last && (rd_old > 0 || ar_hs));
      if (clear_i) begin
        m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
        m_err = '0;
      end else begin
        m_aw = sat(m_aw, aw_hs);
        m_w  = sat(m_w, w_hs);
        m_b  = sat(m_b, b_hs);
        m_ar = sat(m_ar, ar_hs);
        m_r  = sat(m_r, r_hs);
        m_err = m_err | e;
      end
    end
    m_busy = (m_wr != 0) || (m_rd != 0) || (m_beats > 0);
    m_en = 1;
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("m_aw_cnt", aw_cnt, m_aw);
      chk("m_w_cnt",  w_cnt,  m_w);
      chk("m_b_cnt",  b_cnt,  m_b);
      chk("m_ar_cnt", ar_cnt, m_ar);
      chk("m_r_cnt",  r_cnt,  m_r);
      chk("m_wr_out", wr_out, m_wr);
      chk("m_rd_out", rd_out, m_rd);
      chk("m_err",    err,    m_err);
      chk("m_busy",   busy,   m_busy);
    end
  end

  task automatic hs(input bit aw, input bit [7:0] len, input bit w, input bit wl,
                    input bit b, input bit ar, input bit r, input bit rl);
    @(negedge clk);
    req = '0; rsp = '0; rst_i = 1'b0; clear_i = 1'b0;
    req.aw_valid = aw; rsp.aw_ready = aw; req.aw_len = len;
    req.w_valid  = w;  rsp.w_ready  = w;  req.w_last = wl;
    rsp.b_valid  = b;  req.b_ready  = b;
    req.ar_valid = ar; rsp.ar_ready = ar;
    rsp.r_valid  = r;  req.r_ready  = r;  rsp.r_last = rl;
  endtask

  task automatic idle();
    @(negedge clk);
    req = '0; rsp = '0; rst_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic stall();
    @(negedge clk);
    req = '0; rsp = '0;
    req.aw_valid = 1'b1; req.aw_len = 8'd5;
    rsp.w_ready  = 1'b1;
    rsp.b_valid  = 1'b1;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; rsp = '0; clear_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_aw_cnt", aw_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);

    // Normal 4-beat burst, preceded by valid-without-ready cycles
    stall();
    hs(1, 8'd3, 0, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    chk("mid_w_cnt", w_cnt, 2);
    chk("mid_busy", busy, 1);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("ok_aw_cnt", aw_cnt, 1);
    chk("ok_w_cnt", w_cnt, 4);
    chk("ok_b_cnt", b_cnt, 1);
    chk("ok_err", err, 0);
    chk("ok_busy", busy, 0);

    // Short burst, then a W that must be an orphan because the FIFO drained
    do_reset();
    hs(1, 8'd3, 0, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("short_err", err, 5'b00001);
    chk("short_busy", busy, 0);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    idle();
    chk("short_orphan_err", err, 5'b00011);

    // Orphan W, then AW with W-last in the same cycle
    do_reset();
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    idle();
    chk("orphan_err", err, 5'b00010);
    do_reset();
    hs(1, 8'd0, 1, 1, 0, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("same_cyc_err", err, 0);
    chk("same_cyc_w_cnt", w_cnt, 1);
    chk("same_cyc_busy", busy, 0);

    // Overrun: len=1 but a second non-last beat arrives
    do_reset();
    hs(1, 8'd1, 0, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    chk("ovr_err", err, 5'b00001);
    chk("ovr_busy", busy, 1);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("ovr_end_busy", busy, 0);

    // Nine AWs into an 8-deep FIFO, then drain the first two bursts cleanly
    do_reset();
    for (int i = 0; i < 9; i++) hs(1, 8'(i), 0, 0, 0, 0, 0, 0);
    idle();
    chk("ovf_err", err, 5'b10000);
    chk("ovf_aw_cnt", aw_cnt, 9);
    chk("ovf_wr_out", wr_out, 9);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 1, 0, 0, 0, 0);
    idle();
    chk("drain_err", err, 5'b10000);

    // Orphan B and R, then clear with a simultaneous AR
    do_reset();
    hs(0, 0, 0, 0, 1, 0, 0, 0);
    hs(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    chk("br_err", err, 5'b01100);
    chk("br_b_cnt", b_cnt, 1);
    chk("br_r_cnt", r_cnt, 1);
    chk("br_wr_out", wr_out, 0);
    hs(0, 0, 0, 0, 0, 1, 0, 0);
    clear_i = 1'b1;
    idle();
    chk("clr_err", err, 0);
    chk("clr_ar_cnt", ar_cnt, 0);
    chk("clr_b_cnt", b_cnt, 0);
    chk("clr_rd_out", rd_out, 1);
    chk("clr_busy", busy, 1);
    hs(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    chk("clr_rd_done", rd_out, 0);
    chk("clr_r_cnt", r_cnt, 1);

    // Saturation with 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hs(0, 0, 0, 0, 0, 1, 0, 0);
      if (i % 3 == 0) hs(0, 0, 0, 0, 0, 0, 1, 0);
      hs(0, 0, 0, 0, 0, 0, 1, 1);
    end
    idle();
    chk("sat_ar_cnt", ar_cnt, 15);
    chk("sat_r_cnt", r_cnt, 15);
    chk("sat_rd_out", rd_out, 0);

    // Reset mid-burst discards it silently
    do_reset();
    hs(1, 8'd3, 0, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    hs(1, 8'd0, 1, 1, 0, 0, 0, 0);
    idle();
    chk("post_rst_err", err, 0);

    idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
